// File: rtl/module_input_conditioner.sv
// Input conditioner: synchronises and debounces the slide switches and push-button,
// then turns each accepted button press into a single-cycle clock-enable strobe.
module module_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  output logic [WIDTH-1:0] dp_i,
  output logic             dp_ce,
  output logic             btn_db
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } state_t;

  logic [N-1:0] w_raw;
  logic [N-1:0] w_sync;
  logic [N-1:0] w_stable;
  logic [N-1:0] r_sync [SYNC_STAGES];

  state_t r_state;
  state_t w_state_next;
  logic   r_ce;
  logic   w_ce_next;

  // Button rides along as the top bit so it shares the same sync/debounce path.
  assign w_raw  = {btn_raw, sw_raw};
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_db
      logic [CW-1:0] r_cnt;
      logic          r_stable;

      // Any cycle that agrees with the accepted level restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (w_sync[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_stable <= w_sync[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ce    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ce    <= w_ce_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ce_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_stable[WIDTH]) begin
          w_state_next = ST_PRESSED;
          w_ce_next    = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!w_stable[WIDTH]) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign dp_i   = w_stable[WIDTH-1:0];
  assign btn_db = w_stable[WIDTH];
  assign dp_ce  = r_ce;

endmodule

// File: tb/tb_module_input_conditioner.sv
// Bench for module_input_conditioner: constant vector table, directed corner sequences,
// and random stimulus checked every cycle against a sliding-window reference model.
module tb_module_input_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic         btn_raw;
  logic [W-1:0] dp_i;
  logic         dp_ce;
  logic         btn_db;

  always #5 clk = ~clk;

  module_input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .btn_raw(btn_raw),
    .dp_i   (dp_i),
    .dp_ce  (dp_ce),
    .btn_db (btn_db)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a level is accepted once the last D synchronised samples
  // all disagree with it; the strobe is a one-cycle-late rising-edge detect of btn_db.
  logic [W:0] m_sync [SS];
  logic [W:0] m_hist [D];
  logic [W:0] m_stable;
  logic       m_db_prev;
  logic       m_ce;

  typedef struct {
    logic         r;
    logic [W-1:0] sw;
    logic         b;
    logic [W-1:0] e_dp;
    logic         e_db;
    logic         e_ce;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [W-1:0] sw, input logic b);
    logic [W:0] s_old;
    logic       all_diff;
    if (r) begin
      for (int i = 0; i < SS; i++) m_sync[i] = '0;
      for (int i = 0; i < D; i++) m_hist[i] = '0;
      m_stable  = '0;
      m_db_prev = 1'b0;
      m_ce      = 1'b0;
    end else begin
      s_old = m_sync[SS-1];
      for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s_old;
      m_ce      = m_stable[W] & ~m_db_prev;
      m_db_prev = m_stable[W];
      for (int k = 0; k <= W; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (m_hist[j][k] == m_stable[k]) all_diff = 1'b0;
        end
        if (all_diff) m_stable[k] = ~m_stable[k];
      end
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = {b, sw};
    end
  endtask

  task automatic cycle(input logic r, input logic [W-1:0] sw, input logic b);
    rst     = r;
    sw_raw  = sw;
    btn_raw = b;
    @(posedge clk);
    model_step(r, sw, b);
    #1;
    check("model_dp_i", 32'(dp_i), 32'(m_stable[W-1:0]));
    check("model_btn_db", 32'(btn_db), 32'(m_stable[W]));
    check("model_dp_ce", 32'(dp_ce), 32'(m_ce));
  endtask

  function automatic void add(input logic r, input logic [W-1:0] sw, input logic b,
                              input logic [W-1:0] dp, input logic db, input logic ce);
    vec_t v;
    v.r = r; v.sw = sw; v.b = b; v.e_dp = dp; v.e_db = db; v.e_ce = ce;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    int pulses;
    logic [W-1:0] rsw;
    logic         rbtn;

    for (int i = 0; i < 8; i++) add(1'b0, 4'h5, 1'b0, (i >= 5) ? 4'h5 : 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 4'h0, 1'b0, (i >= 5) ? 4'h0 : 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 4'h0, 1'b1, 4'h0, (i >= 5), (i == 6));
    for (int i = 0; i < 8; i++) add(1'b0, 4'h0, 1'b0, 4'h0, (i < 5), 1'b0);

    // Reset with random pins: outputs must hold at zero throughout.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, W'($urandom), 1'($urandom));
      check("rst_dp_i", 32'(dp_i), 32'h0);
      check("rst_btn_db", 32'(btn_db), 32'h0);
      check("rst_dp_ce", 32'(dp_ce), 32'h0);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'h0, 1'b0);

    // Switch latency and single-pulse button press from the vector table.
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].sw, vecs[i].b);
      check($sformatf("tbl%0d_dp_i", i), 32'(dp_i), 32'(vecs[i].e_dp));
      check($sformatf("tbl%0d_btn_db", i), 32'(btn_db), 32'(vecs[i].e_db));
      check($sformatf("tbl%0d_dp_ce", i), 32'(dp_ce), 32'(vecs[i].e_ce));
    end

    // 3-cycle glitch is ignored and leaves the count cleared for the next change.
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    check("glitch_dp_i", 32'(dp_i), 32'h0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 4'h1, 1'b0);
      if (dp_i[0]) begin
        n = i;
        break;
      end
    end
    check("glitch_recount_latency", 32'(n), 32'd6);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b0);

    // Long hold: one pulse only.
    pulses = 0;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      cycle(1'b0, 4'h0, 1'b1);
      if (dp_ce) pulses++;
      if (btn_db && n == 0) n = i;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_db_latency", 32'(n), 32'd6);
    pulses = 0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 4'h0, 1'b0);
      if (dp_ce) pulses++;
      if (!btn_db && n == 0) n = i;
    end
    check("release_pulses", 32'(pulses), 32'd0);
    check("release_db_latency", 32'(n), 32'd6);

    // Bouncing press then steady: exactly one pulse.
    pulses = 0;
    cycle(1'b0, 4'h0, 1'b1); if (dp_ce) pulses++;
    cycle(1'b0, 4'h0, 1'b0); if (dp_ce) pulses++;
    cycle(1'b0, 4'h0, 1'b1); if (dp_ce) pulses++;
    cycle(1'b0, 4'h0, 1'b0); if (dp_ce) pulses++;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 4'h0, 1'b1);
      if (dp_ce) pulses++;
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b0);

    // Reset on the third debounce cycle discards the partial count.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'hF, 1'b0);
    cycle(1'b1, 4'hF, 1'b0);
    check("rst_mid_dp_i", 32'(dp_i), 32'h0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 4'hF, 1'b0);
      if (dp_i == 4'hF) begin
        n = i;
        break;
      end
    end
    check("rst_mid_relatency", 32'(n), 32'd6);

    // Random soak against the model.
    rsw  = 4'hF;
    rbtn = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) rsw = W'($urandom);
      if ($urandom_range(5) == 0) rbtn = ~rbtn;
      cycle(($urandom_range(149) == 0), rsw, rbtn);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
